// File: rtl/axi_burst_scheduler_pkg.sv
// Shared types and constants for the AXI burst scheduler.
package axi_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    ISSUE,
    WAIT,
    DONE
  } sched_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned AXI_4K_BYTES = 4096;

  // SLVERR and DECERR both mark the transfer as failed; OKAY/EXOKAY do not.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi_burst_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 with wrap.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic             found;
  logic [IDX_W-1:0] cand;

  // First requester after the pointer wins; nothing is granted unless enabled.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((32'(ptr) + off) % NUM_REQ);
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/axi_burst_scheduler.sv
// Shares one AXI burst engine between NUM_REQ clients, splitting each
// descriptor into bursts of at most BURST_LEN beats that never cross 4 KB.
module axi_burst_scheduler
  import axi_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                            m00_axi_aclk,
  input  logic                            m00_axi_aresetn,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_beats,
  output logic [NUM_REQ-1:0]              req_done,
  output logic                            req_error,
  output logic                            cmd_valid,
  input  logic                            cmd_ready,
  output logic                            cmd_write,
  output logic [ADDR_WIDTH-1:0]           cmd_addr,
  output logic [7:0]                      cmd_len,
  input  logic                            cmd_done,
  input  logic [1:0]                      cmd_resp,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam int unsigned BSHIFT = $clog2(BYTES);

  sched_state_t          state;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      owner;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic [8:0]            blen_q;
  logic                  err_sticky;

  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      gidx;
  logic                  arb_en;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LEN_WIDTH-1:0]  sel_beats;
  logic [12:0]           to4k_bytes;
  logic [12:0]           to4k_beats;
  logic [8:0]            blen_c;
  logic                  resp_err;

  // Arbitration only in IDLE and never while reset is held, so req_ready stays low in reset.
  assign arb_en = (state == IDLE) && m00_axi_aresetn;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign req_ready = grant;
  assign grant_id  = owner;
  assign resp_err  = resp_is_error(cmd_resp);

  // Steer the winning client's descriptor fields.
  always_comb begin
    sel_addr  = '0;
    sel_beats = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (32'(gidx) == i) begin
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_beats = req_beats[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  assign to4k_bytes = 13'(AXI_4K_BYTES) - {1'b0, addr_q[11:0]};
  assign to4k_beats = to4k_bytes >> BSHIFT;

  // Burst length = min(remaining, BURST_LEN, beats left before the 4 KB line).
  always_comb begin
    blen_c = 9'(BURST_LEN);
    if (32'(to4k_beats) < 32'(blen_c)) blen_c = 9'(to4k_beats);
    if (32'(remaining_q) < 32'(blen_c)) blen_c = 9'(remaining_q);
  end

  // Scheduler FSM with registered command and status outputs.
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      state       <= IDLE;
      rr_ptr      <= IDX_W'(NUM_REQ - 1);
      owner       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      blen_q      <= '0;
      err_sticky  <= 1'b0;
      req_done    <= '0;
      req_error   <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_write   <= 1'b0;
      cmd_addr    <= '0;
      cmd_len     <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            owner       <= gidx;
            rr_ptr      <= gidx;
            write_q     <= req_write[gidx];
            addr_q      <= sel_addr & ~ADDR_WIDTH'(BYTES - 1);
            remaining_q <= sel_beats;
            busy        <= 1'b1;
            if (sel_beats == '0) begin
              // Zero-length descriptors complete without touching the engine.
              state           <= DONE;
              req_done[gidx]  <= 1'b1;
              req_error       <= err_sticky;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          blen_q    <= blen_c;
          cmd_len   <= 8'(blen_c - 9'd1);
          cmd_addr  <= addr_q;
          cmd_write <= write_q;
          cmd_valid <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cmd_done) begin
            err_sticky  <= err_sticky | resp_err;
            addr_q      <= addr_q + (ADDR_WIDTH'(blen_q) << BSHIFT);
            remaining_q <= remaining_q - LEN_WIDTH'(blen_q);
            if (remaining_q == LEN_WIDTH'(blen_q)) begin
              // Completion pulse is raised here so it lands exactly one cycle after cmd_done.
              state           <= DONE;
              req_done[owner] <= 1'b1;
              req_error       <= err_sticky | resp_err;
            end else begin
              state <= CALC;
            end
          end
        end
        DONE: begin
          req_done   <= '0;
          req_error  <= 1'b0;
          err_sticky <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_scheduler.sv
// Self-checking bench for axi_burst_scheduler: directed vector table,
// hand sequences for round-robin and reset, and randomized transfers
// checked against a burst-splitting reference model.
module tb_axi_burst_scheduler;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [63:0] req_addr;
  logic [31:0] req_beats;
  logic [1:0]  req_done;
  logic        req_error;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        cmd_done;
  logic [1:0]  cmd_resp;
  logic [0:0]  grant_id;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int rr_last;

  logic [31:0] qa[$];
  int          ql[$];

  typedef struct {
    int          client;
    bit          wr;
    logic [31:0] addr;
    int          beats;
    int          stall;
    int          err_burst;
    logic [1:0]  err_resp;
    int          exp_bursts;
    bit          exp_err;
  } vec_t;

  vec_t vecs[8];
  int   exp_rr[4];

  axi_burst_scheduler #(
    .NUM_REQ    (2),
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .BURST_LEN  (16),
    .LEN_WIDTH  (16)
  ) dut (
    .m00_axi_aclk    (clk),
    .m00_axi_aresetn (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_beats       (req_beats),
    .req_done        (req_done),
    .req_error       (req_error),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_addr        (cmd_addr),
    .cmd_len         (cmd_len),
    .cmd_done        (cmd_done),
    .cmd_resp        (cmd_resp),
    .grant_id        (grant_id),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_desc(input int c, input bit wr, input logic [31:0] addr, input int beats);
    req_write[c]          = wr;
    req_addr[c*32 +: 32]  = addr;
    req_beats[c*16 +: 16] = 16'(beats);
  endtask

  // Reference splitter: word-align, then take min(remaining, 16, beats to next 4 KB line).
  task automatic plan(input logic [31:0] addr, input int beats);
    logic [31:0] a;
    int rem, n, to4k;
    qa.delete();
    ql.delete();
    a   = addr & ~32'h3;
    rem = beats;
    while (rem > 0) begin
      to4k = (4096 - int'(a % 32'd4096)) / 4;
      n = rem;
      if (n > 16) n = 16;
      if (n > to4k) n = to4k;
      qa.push_back(a);
      ql.push_back(n - 1);
      a   = a + 32'(n * 4);
      rem = rem - n;
    end
  endtask

  // Wait for a grant among mask; expected winner is the first requester after the last winner.
  task automatic accept(input logic [1:0] mask, input bit hold, output int win);
    int exp_w;
    exp_w = -1;
    for (int off = 1; off <= 2; off++) begin
      if (exp_w < 0 && mask[(rr_last + off) % 2]) exp_w = (rr_last + off) % 2;
    end
    win = -1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (req_ready != 2'b00) begin
        win = req_ready[1] ? 1 : 0;
        break;
      end
      @(negedge clk);
    end
    if (win < 0) begin
      chk("accept_timeout", req_ready, 64'(1) << exp_w);
      win = exp_w;
      return;
    end
    chk("accept_onehot", req_ready, 64'(1) << win);
    chk("rr_winner", win, exp_w);
    rr_last = win;
    @(posedge clk);
    #1;
    if (!hold) req_valid[win] = 1'b0;
  endtask

  // Play the engine for an accepted transfer whose bursts are in qa/ql.
  task automatic serve(input int c, input bit wr, input int beats, input int stall,
                       input int err_burst, input logic [1:0] err_resp,
                       output int nb, output bit got_err);
    bit eflag;
    int k;
    logic [1:0] r;
    nb = 0;
    got_err = 1'b0;
    eflag = 1'b0;
    @(negedge clk);
    if (beats == 0) begin
      chk("zl_done", req_done, 64'(1) << c);
      chk("zl_err", req_error, 0);
      chk("zl_cmdv", cmd_valid, 0);
      got_err = req_error;
      @(negedge clk);
      chk("zl_pulse", req_done, 0);
      chk("zl_cmdv2", cmd_valid, 0);
      return;
    end
    chk("calc_cmdv", cmd_valid, 0);
    for (int i = 0; i < qa.size(); i++) begin
      k = 0;
      while (!cmd_valid && k < 20) begin
        @(negedge clk);
        k++;
      end
      if (!cmd_valid) begin
        chk("cmd_timeout", cmd_valid, 1);
        return;
      end
      chk("cmd_latency", k, 1);
      chk("cmd_addr", cmd_addr, qa[i]);
      chk("cmd_len", cmd_len, ql[i]);
      chk("cmd_write", cmd_write, wr);
      chk("grant_id", grant_id, c);
      chk("busy_burst", busy, 1);
      nb++;
      if (i == 0) begin
        for (int s = 0; s < stall; s++) begin
          cmd_ready = 1'b0;
          cmd_done  = (s == 0);
          cmd_resp  = (s == 0) ? 2'b11 : 2'b00;
          @(negedge clk);
          cmd_done = 1'b0;
          cmd_resp = 2'b00;
          chk("stall_valid", cmd_valid, 1);
          chk("stall_addr", cmd_addr, qa[i]);
          chk("stall_len", cmd_len, ql[i]);
          chk("stall_write", cmd_write, wr);
        end
      end
      cmd_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_ready = 1'b0;
      chk("cmd_drop", cmd_valid, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      r = (i == err_burst) ? err_resp : 2'($urandom_range(0, 1));
      eflag = eflag | r[1];
      cmd_done = 1'b1;
      cmd_resp = r;
      @(negedge clk);
      cmd_done = 1'b0;
      cmd_resp = 2'b00;
    end
    chk("done_bit", req_done, 64'(1) << c);
    chk("done_err", req_error, eflag);
    chk("done_busy", busy, 1);
    got_err = req_error;
    @(negedge clk);
    chk("done_pulse", req_done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int w, nb, c, beats, stall, eb;
    bit ge, wr;
    logic [31:0] addr;

    vecs[0] = '{0, 1'b1, 32'h4000_0000, 40,  3, -1, 2'b00, 3,  1'b0};
    vecs[1] = '{1, 1'b0, 32'h4000_0FF0, 16,  0, -1, 2'b00, 2,  1'b0};
    vecs[2] = '{0, 1'b1, 32'h4000_0000, 48,  0,  1, 2'b10, 3,  1'b1};
    vecs[3] = '{1, 1'b0, 32'h2000_0100, 8,   0, -1, 2'b00, 1,  1'b0};
    vecs[4] = '{0, 1'b0, 32'h0000_1000, 0,   0, -1, 2'b00, 0,  1'b0};
    vecs[5] = '{1, 1'b1, 32'h4000_0FFE, 5,   1, -1, 2'b00, 2,  1'b0};
    vecs[6] = '{0, 1'b0, 32'hFFFF_FFF0, 10,  0,  1, 2'b11, 2,  1'b1};
    vecs[7] = '{1, 1'b1, 32'h0000_0300, 256, 0, -1, 2'b00, 16, 1'b0};
    exp_rr  = '{0, 1, 0, 1};

    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_write = '0;
    req_addr  = '0;
    req_beats = '0;
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    cmd_resp  = 2'b00;
    rr_last   = 1;
    set_desc(0, 1'b1, 32'h1000, 1);
    set_desc(1, 1'b0, 32'h2000, 1);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_done", req_done, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_req_error", req_error, 0);
    chk("rst_cmd_len", cmd_len, 0);
    chk("rst_cmd_addr", cmd_addr, 0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin with both clients requesting continuously.
    req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      accept(2'b11, 1'b1, w);
      chk("rr_order", w, exp_rr[t]);
      plan((w == 0) ? 32'h1000 : 32'h2000, 1);
      serve(w, (w == 0), 1, 0, -1, 2'b00, nb, ge);
      if (t == 3) req_valid = 2'b00;
    end

    // Directed vector table.
    foreach (vecs[i]) begin
      set_desc(vecs[i].client, vecs[i].wr, vecs[i].addr, vecs[i].beats);
      plan(vecs[i].addr, vecs[i].beats);
      req_valid = 2'(1 << vecs[i].client);
      accept(req_valid, 1'b0, w);
      serve(vecs[i].client, vecs[i].wr, vecs[i].beats, vecs[i].stall,
            vecs[i].err_burst, vecs[i].err_resp, nb, ge);
      chk("vec_bursts", nb, vecs[i].exp_bursts);
      chk("vec_err", ge, vecs[i].exp_err);
    end

    // Randomized transfers, biased toward 4 KB boundaries.
    for (int n = 0; n < 25; n++) begin
      c  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1)
        addr = ($urandom & 32'hFFFF_F000) | (32'hF00 + 32'($urandom_range(0, 255)));
      else
        addr = $urandom;
      beats = int'($urandom_range(0, 70));
      stall = int'($urandom_range(0, 2));
      eb    = int'($urandom_range(0, 6));
      set_desc(c, wr, addr, beats);
      plan(addr, beats);
      req_valid = 2'(1 << c);
      accept(req_valid, 1'b0, w);
      serve(c, wr, beats, stall, eb, 2'($urandom_range(2, 3)), nb, ge);
      chk("rnd_bursts", nb, qa.size());
    end

    // Reset while a burst is outstanding.
    set_desc(1, 1'b1, 32'h0000_5000, 40);
    req_valid = 2'b10;
    accept(2'b10, 1'b0, w);
    @(negedge clk);
    @(negedge clk);
    chk("mid_cmdv", cmd_valid, 1);
    cmd_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_ready = 1'b0;
    chk("mid_busy", busy, 1);
    chk("mid_grant", grant_id, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cmd_valid", cmd_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_req_done", req_done, 0);
    chk("arst_grant_id", grant_id, 0);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    chk("arst_hold_done", req_done, 0);
    rst_n   = 1'b1;
    rr_last = 1;
    set_desc(0, 1'b0, 32'h0000_8000, 1);
    set_desc(1, 1'b1, 32'h0000_9000, 1);
    req_valid = 2'b11;
    accept(2'b11, 1'b1, w);
    chk("post_rst_first", w, 0);
    plan(32'h0000_8000, 1);
    serve(0, 1'b0, 1, 0, -1, 2'b00, nb, ge);
    accept(2'b11, 1'b1, w);
    chk("post_rst_second", w, 1);
    plan(32'h0000_9000, 1);
    serve(1, 1'b1, 1, 0, -1, 2'b00, nb, ge);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    chk("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_burst_scheduler.md
Name: axi_burst_scheduler

Overview:
- Shares one AXI4 burst master engine between NUM_REQ NPU clients, such as weight fetch, activation fetch and result store.
- Each client submits a transfer descriptor: direction, byte address and total beat count.
- The scheduler arbitrates round-robin between clients and splits each transfer into AXI-legal bursts. Bursts are at most BURST_LEN beats and never cross a 4 KB boundary.
- It issues one burst command at a time to the master engine and reports completion and error status back to the owning client.

Parameters:
- NUM_REQ, 2, number of requesting clients (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, AXI data width; beat size in bytes BYTES = DATA_WIDTH/8.
- BURST_LEN, 16, maximum beats per burst (1..256).
- LEN_WIDTH, 16, width of the total beat count in a descriptor.

Ports:
- m00_axi_aclk, in, 1, clock.
- m00_axi_aresetn, in, 1, asynchronous active-low reset.
- req_valid, in, NUM_REQ, per-client descriptor valid.
- req_ready, out, NUM_REQ, per-client descriptor accept.
- req_write, in, NUM_REQ, 1 = write, 0 = read.
- req_addr, in, NUM_REQ*ADDR_WIDTH, packed start byte addresses.
- req_beats, in, NUM_REQ*LEN_WIDTH, packed total beat counts.
- req_done, out, NUM_REQ, one-cycle completion pulse to the owning client.
- req_error, out, 1, error status; valid only while any req_done bit is 1.
- cmd_valid, out, 1, burst command valid.
- cmd_ready, in, 1, engine accepts command.
- cmd_write, out, 1, burst direction.
- cmd_addr, out, ADDR_WIDTH, burst start address.
- cmd_len, out, 8, AXI LEN value (beats-1).
- cmd_done, in, 1, one-cycle pulse from the engine: burst finished (B for writes, RLAST beat for reads).
- cmd_resp, in, 2, worst response of the finished burst; sampled with cmd_done.
- grant_id, out, $clog2(NUM_REQ), current owner index, for data-path steering.
- busy, out, 1, high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs return to 0 and the FSM returns to IDLE.
  - The round-robin pointer resets to NUM_REQ-1, so client 0 has first priority.
  - Any in-flight transfer is discarded and gets no req_done.
- FSM states: IDLE, CALC, ISSUE, WAIT, DONE.
- IDLE:
  - If any req_valid is set, rr_arbiter selects a winner, searching from pointer+1 upward with wrap.
  - req_ready[winner] is asserted combinationally that cycle; this is the handshake.
  - Registers captured: owner, write, addr (low log2(BYTES) bits forced to 0), remaining = beats.
  - The pointer updates to the winner.
  - Next state is CALC, or DONE if beats == 0.
- CALC (1 cycle):
  - to4k = (4096 - addr[11:0]) / BYTES.
  - blen = min(remaining, BURST_LEN, to4k).
  - Register cmd_len = blen-1; next state ISSUE.
- ISSUE:
  - cmd_valid = 1; cmd_write, cmd_addr and cmd_len are held stable until cmd_ready.
  - On the handshake cmd_valid drops in the next cycle and the FSM goes to WAIT.
- WAIT:
  - On cmd_done: err_sticky |= cmd_resp[1]; addr += blen*BYTES; remaining -= blen.
  - If remaining == 0 go to DONE, else go to CALC.
  - cmd_done outside WAIT is ignored.
- DONE (1 cycle):
  - req_done[owner] = 1 and req_error = err_sticky.
  - err_sticky is then cleared and the FSM goes to IDLE.
- Errors (SLVERR/DECERR) do not abort the transfer; all remaining bursts are still issued.
- Latency:
  - Accept at cycle T gives cmd_valid at T+2.
  - The last cmd_done at cycle D gives req_done at D+1; the next accept is possible at D+2.
- Only one burst is outstanding at a time; the engine owns data beats and strobes.
- A client must hold its descriptor stable while req_valid is high and not yet accepted.
- Address arithmetic wraps modulo 2^ADDR_WIDTH without a flag.

Decomposition:
- Package axi_sched_pkg holds:
  - the FSM state enum;
  - AXI response codes RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  - the constant AXI_4K_BYTES = 4096.
- Sub-module rr_arbiter (parameter NUM_REQ) takes request, pointer and enable, and outputs a one-hot grant and a binary index; it is purely combinational.
- The splitter arithmetic stays inline.

Test Plan:
- Split and stall: req0 write, addr 0x40000000, beats 40, with cmd_ready held low 3 cycles on the first command.
  - Required: commands (0x40000000, len 15), (0x40000040, len 15), (0x40000080, len 7).
  - Fields stay stable during the stall.
  - Exactly one req_done[0] pulse, with req_error 0.
- 4 KB crossing: req1 read, addr 0x40000FF0, beats 16.
  - Required: (0x40000FF0, len 3) then (0x40001000, len 11), with cmd_write 0.
- Round-robin fairness: req_valid = 2'b11 held continuously with 1-beat descriptors.
  - Required: grants 0,1,0,1, and grant_id matches each owner while busy.
- Error propagation: 3-burst transfer, cmd_resp = 2'b10 on the second cmd_done.
  - Required: all 3 commands are issued and req_done carries req_error = 1.
  - The next transfer with OKAY responses reports req_error = 0.
- Zero length: req0 with beats 0 accepted at T.
  - Required: no cmd_valid, req_done[0] at T+1, req_error 0.
- Reset mid-WAIT: drop m00_axi_aresetn during WAIT.
  - Required: cmd_valid, busy, req_done and grant_id go to 0 immediately.
  - After release with both clients requesting, client 0 is granted first.
